// File: rtl/izh_state_update.sv
// Izhikevich v/w state register: integrates dv/dw, applies the spike/reset rule, and hands the result off over valid/ready.
// Optional spike counter output is enabled by defining IZH_SPIKE_COUNT_EN.
module izh_state_update #(
  parameter int N = 18,
  parameter int Q = 8,
  parameter logic signed [N-1:0] V_TH   = 18'sd7680,
  parameter logic signed [N-1:0] V_INIT = -18'sd16640,
  parameter logic signed [N-1:0] W_INIT = -18'sd3328
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] dv,
  input  logic signed [N-1:0] dw,
  input  logic signed [N-1:0] c,
  input  logic signed [N-1:0] d,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] v_out,
  output logic signed [N-1:0] w_out,
  output logic                spike,
  output logic                sat
`ifdef IZH_SPIKE_COUNT_EN
  ,
  output logic [15:0]         spike_count
`endif
);

  if (Q < 0 || Q >= N) begin : g_q_check
    $error("izh_state_update: Q must lie in [0, N)");
  end

  typedef enum logic [1:0] {IDLE, ADD, CHECK, HOLD} state_t;

  localparam logic signed [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  state_t state, next_state;

  logic signed [N-1:0] dv_r, dw_r, v_sum, w_sum;
  logic                sum_sat;
  logic [N:0]          v_add, w_add, w_spk;
  logic                hit;

  // Returns {overflow, clamped sum}; overflow shows up as disagreement of the two top bits.
  function automatic logic [N:0] sat_add(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    logic signed [N:0] s;
    s = {a[N-1], a} + {b[N-1], b};
    if (s[N] != s[N-1]) return {1'b1, (s[N] ? MIN_VAL : MAX_VAL)};
    return {1'b0, s[N-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = ADD;
      ADD:     next_state = CHECK;
      CHECK:   next_state = HOLD;
      HOLD:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && !rst;
  end

  always_comb begin
    v_add = sat_add(v_out, dv_r);
    w_add = sat_add(w_out, dw_r);
    w_spk = sat_add(w_sum, d);
    hit   = (v_sum >= V_TH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_out     <= V_INIT;
      w_out     <= W_INIT;
      out_valid <= 1'b0;
      spike     <= 1'b0;
      sat       <= 1'b0;
      dv_r      <= '0;
      dw_r      <= '0;
      v_sum     <= '0;
      w_sum     <= '0;
      sum_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dv_r <= dv;
            dw_r <= dw;
          end
        end
        ADD: begin
          v_sum   <= v_add[N-1:0];
          w_sum   <= w_add[N-1:0];
          sum_sat <= v_add[N] | w_add[N];
        end
        CHECK: begin
          if (hit) begin
            v_out <= c;
            w_out <= w_spk[N-1:0];
            sat   <= sum_sat | w_spk[N];
          end else begin
            v_out <= v_sum;
            w_out <= w_sum;
            sat   <= sum_sat;
          end
          spike     <= hit;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            spike     <= 1'b0;
            sat       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IZH_SPIKE_COUNT_EN
  // Saturating count of spikes, bumped at the CHECK edge.
  always_ff @(posedge clk) begin
    if (rst)
      spike_count <= '0;
    else if (state == CHECK && hit && spike_count != 16'hFFFF)
      spike_count <= spike_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_izh_state_update.sv
// Self-checking bench for izh_state_update: a behavioural model pushes expected updates into a scoreboard queue.
// Also checks spike_count when IZH_SPIKE_COUNT_EN is defined.
module tb_izh_state_update;
  localparam int N = 18;
  localparam int VMAX = 131071;
  localparam int VMIN = -131072;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, spike, sat;
  logic signed [N-1:0] dv, dw, c, d, v_out, w_out;
`ifdef IZH_SPIKE_COUNT_EN
  logic [15:0] spike_count;
`endif

  typedef struct {
    int v;
    int w;
    bit spk;
    bit st;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int model_v, model_w, model_cnt;
  int checks = 0;
  int fails = 0;

  izh_state_update dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dv(dv), .dw(dw), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .v_out(v_out), .w_out(w_out), .spike(spike), .sat(sat)
`ifdef IZH_SPIKE_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit ovf(input int x);
    return (x > VMAX) || (x < VMIN);
  endfunction

  function automatic int clamp(input int x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  // Golden model of one full update; result pushed to the scoreboard.
  task automatic predict(input int dvi, input int dwi, input int ci, input int di);
    exp_t e;
    int vs, ws;
    bit s;
    vs = clamp(model_v + dvi);
    ws = clamp(model_w + dwi);
    s  = ovf(model_v + dvi) | ovf(model_w + dwi);
    if (vs >= 7680) begin
      s = s | ovf(ws + di);
      model_v = ci;
      model_w = clamp(ws + di);
      e.spk = 1'b1;
      if (model_cnt < 65535) model_cnt++;
    end else begin
      model_v = vs;
      model_w = ws;
      e.spk = 1'b0;
    end
    e.v = model_v;
    e.w = model_w;
    e.st = s;
    e.cnt = model_cnt;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_v = -16640;
    model_w = -3328;
    model_cnt = 0;
    sb.delete();
  endtask

  task automatic start_update(input int dvi, input int dwi, input int ci, input int di);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!in_ready) begin
      fails++;
      $display("[TB] FAIL in_ready_wait: got %0b, expected 1", in_ready);
    end
    dv = dvi[N-1:0];
    dw = dwi[N-1:0];
    c  = ci[N-1:0];
    d  = di[N-1:0];
    in_valid = 1'b1;
    predict(dvi, dwi, ci, di);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_and_check(input string name);
    int waited = 0;
    exp_t e;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited !== 2) begin
      fails++;
      $display("[TB] FAIL %s latency: got %0d cycles after E0, expected 2", name, waited);
    end
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected entry", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (v_out !== e.v[N-1:0]) begin
      fails++;
      $display("[TB] FAIL %s v_out: got %0d, expected %0d", name, v_out, e.v);
    end
    checks++;
    if (w_out !== e.w[N-1:0]) begin
      fails++;
      $display("[TB] FAIL %s w_out: got %0d, expected %0d", name, w_out, e.w);
    end
    checks++;
    if (spike !== e.spk || sat !== e.st) begin
      fails++;
      $display("[TB] FAIL %s spike/sat: got %0b/%0b, expected %0b/%0b", name, spike, sat, e.spk, e.st);
    end
`ifdef IZH_SPIKE_COUNT_EN
    checks++;
    if (spike_count !== e.cnt[15:0]) begin
      fails++;
      $display("[TB] FAIL %s spike_count: got %0d, expected %0d", name, spike_count, e.cnt);
    end
`endif
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || spike !== 1'b0 || sat !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s handshake: got valid/spike/sat/ready %0b%0b%0b%0b, expected 0001",
               name, out_valid, spike, sat, in_ready);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (v_out !== -18'sd16640 || w_out !== -18'sd3328 || out_valid !== 1'b0 || spike !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: got v=%0d w=%0d valid=%0b spike=%0b ready=%0b, expected -16640 -3328 0 0 0",
               v_out, w_out, out_valid, spike, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_ready: got %0b, expected 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_no_spike();
    start_update(256, -64, -16640, 2048);
    wait_and_check("no_spike");
    checks++;
    if (v_out !== -18'sd16384 || w_out !== -18'sd3392) begin
      fails++;
      $display("[TB] FAIL no_spike_const: got v=%0d w=%0d, expected -16384 -3392", v_out, w_out);
    end
    handshake("no_spike");
  endtask

  task automatic test_spike_threshold();
    test_reset();
    start_update(24320, 0, -16640, 2048);
    wait_and_check("spike_th");
    checks++;
    if (spike !== 1'b1 || v_out !== -18'sd16640 || w_out !== -18'sd1280) begin
      fails++;
      $display("[TB] FAIL spike_th_const: got spike=%0b v=%0d w=%0d, expected 1 -16640 -1280", spike, v_out, w_out);
    end
    handshake("spike_th");
  endtask

  task automatic test_w_saturation();
    test_reset();
    start_update(0, 131071, -16640, 2048);
    wait_and_check("wsat_1");
    handshake("wsat_1");
    start_update(0, 131071, -16640, 2048);
    wait_and_check("wsat_2");
    checks++;
    if (w_out !== 18'sd131071 || sat !== 1'b1 || spike !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wsat_const: got w=%0d sat=%0b spike=%0b, expected 131071 1 0", w_out, sat, spike);
    end
    handshake("wsat_2");
  endtask

  task automatic test_backpressure();
    logic signed [N-1:0] hv, hw;
    logic hs;
    test_reset();
    start_update(1000, 50, -16640, 2048);
    wait_and_check("bp_first");
    hv = v_out;
    hw = w_out;
    hs = spike;
    in_valid = 1'b1;
    dv = 18'sd512;
    dw = 18'sd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || v_out !== hv || w_out !== hw || spike !== hs || in_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL bp_hold%0d: got valid=%0b v=%0d w=%0d ready=%0b, expected 1 %0d %0d 0",
                 i, out_valid, v_out, w_out, in_ready, hv, hw);
      end
    end
    handshake("bp");
    start_update(512, 8, -16640, 2048);
    wait_and_check("bp_next");
    handshake("bp_next");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      int rdv;
      int rdw;
      rdv = int'($urandom_range(12000, 0)) - 2000;
      rdw = int'($urandom_range(600, 0)) - 300;
      start_update(rdv, rdw, -16640, 2048);
      wait_and_check("b2b");
      handshake("b2b");
    end
  endtask

  task automatic test_reset_midop();
    start_update(24320, 100, -16640, 2048);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (v_out !== -18'sd16640 || w_out !== -18'sd3328 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_midop: got v=%0d w=%0d valid=%0b ready=%0b, expected -16640 -3328 0 0",
               v_out, w_out, out_valid, in_ready);
    end
    model_v = -16640;
    model_w = -3328;
    model_cnt = 0;
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_midop_after: got valid=%0b ready=%0b, expected 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dv = '0;
    dw = '0;
    c = '0;
    d = '0;
    @(negedge clk);
    test_reset();
    test_no_spike();
    test_spike_threshold();
    test_w_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
